// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS sample-address controller.
package dds_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 16;
    localparam int ROM_LAT   = 2;

    localparam logic [1:0] SEL_COS    = 2'd0;
    localparam logic [1:0] SEL_SQUARE = 2'd1;
    localparam logic [1:0] SEL_TRI    = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dds_state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator: clears, steps by ftw, and reports the carry out as wrap.
module dds_phase_acc #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [ACC_W-1:0] ftw,
    output logic [ACC_W-1:0] acc_nxt,
    output logic             wrap
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, ftw};
        acc_d = acc_q;
        wrap  = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (step) begin
            acc_d = sum[ACC_W-1:0];
            wrap  = sum[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_nxt = acc_d;

endmodule

// File: rtl/dds_ctrl.sv
// DDS burst controller: shadow/active config, period counting, graceful stop
// and a fixed drain for the ROM latency before returning to idle.
module dds_ctrl
    import dds_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [7:0]       cfg_phase,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_periods,
    input  logic             start,
    input  logic             stop,
    output logic             mem_en,
    output logic [1:0]       mem_sel,
    output logic [7:0]       mem_addr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period_cnt,
    output logic [1:0]       dbg_state
);

    localparam int DRAIN_W = $clog2(ROM_LAT + 1);

    dds_state_e state_q, state_d;
    logic [ACC_W-1:0]   ftw_sh_q, ftw_sh_d, ftw_act_q, ftw_act_d;
    logic [7:0]         ph_sh_q, ph_sh_d, ph_act_q, ph_act_d;
    logic [1:0]         sel_sh_q, sel_sh_d, sel_act_q, sel_act_d;
    logic [CNT_W-1:0]   per_sh_q, per_sh_d, per_act_q, per_act_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               stop_pend_q, stop_pend_d;
    logic               done_q, done_d;
    logic               mem_en_q, mem_en_d;
    logic [1:0]         mem_sel_q, mem_sel_d;
    logic [7:0]         mem_addr_q, mem_addr_d;
    logic               cfg_fire, acc_clear, acc_step, acc_wrap;
    logic [ACC_W-1:0]   acc_nxt;

    assign cfg_ready = !rst && (state_q != DRAIN);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign acc_clear = (state_q == IDLE) && start;
    assign acc_step  = (state_q == RUN);

    dds_phase_acc #(.ACC_W(ACC_W)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .step    (acc_step),
        .ftw     (ftw_act_q),
        .acc_nxt (acc_nxt),
        .wrap    (acc_wrap)
    );

    always_comb begin
        state_d     = state_q;
        ftw_sh_d    = ftw_sh_q;
        ph_sh_d     = ph_sh_q;
        sel_sh_d    = sel_sh_q;
        per_sh_d    = per_sh_q;
        ftw_act_d   = ftw_act_q;
        ph_act_d    = ph_act_q;
        sel_act_d   = sel_act_q;
        per_act_d   = per_act_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

        if (cfg_fire) begin
            ftw_sh_d = cfg_ftw;
            ph_sh_d  = cfg_phase;
            sel_sh_d = cfg_sel;
            per_sh_d = cfg_periods;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                    // A config offered alongside start goes live immediately.
                    ftw_act_d   = cfg_fire ? cfg_ftw     : ftw_sh_q;
                    ph_act_d    = cfg_fire ? cfg_phase   : ph_sh_q;
                    sel_act_d   = cfg_fire ? cfg_sel     : sel_sh_q;
                    per_act_d   = cfg_fire ? cfg_periods : per_sh_q;
                end
            end
            RUN: begin
                if (stop) stop_pend_d = 1'b1;
                if (acc_wrap) begin
                    cnt_d     = cnt_inc;
                    ftw_act_d = ftw_sh_q;
                    ph_act_d  = ph_sh_q;
                    sel_act_d = sel_sh_q;
                    per_act_d = per_sh_q;
                    if (((per_act_q != '0) && (cnt_inc == per_act_q)) || stop_pend_q) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end else if (stop_pend_q && (ftw_act_q == '0)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(ROM_LAT - 1)) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // ROM drive is registered off next-state so the address lines up with acc.
        mem_en_d   = (state_d == RUN);
        mem_addr_d = (state_d == RUN) ? acc_nxt[ACC_W-1 -: 8] + ph_act_d : 8'd0;
        mem_sel_d  = (state_d == RUN) ? sel_act_d : mem_sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ftw_sh_q    <= '0;
            ph_sh_q     <= '0;
            sel_sh_q    <= '0;
            per_sh_q    <= '0;
            ftw_act_q   <= '0;
            ph_act_q    <= '0;
            sel_act_q   <= '0;
            per_act_q   <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            ftw_sh_q    <= ftw_sh_d;
            ph_sh_q     <= ph_sh_d;
            sel_sh_q    <= sel_sh_d;
            per_sh_q    <= per_sh_d;
            ftw_act_q   <= ftw_act_d;
            ph_act_q    <= ph_act_d;
            sel_act_q   <= sel_act_d;
            per_act_q   <= per_act_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
            mem_en_q    <= mem_en_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_sel    = mem_sel_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign period_cnt = cnt_q;
    assign dbg_state  = state_q;

endmodule
